bloom_filter_seq: RTL

Parametrised, writable Bloom-filter membership store for the Wordle word checker. Hashes a packed multi-letter word with NUM_HASH linear hashes, one hash per clock, against a register-based FILTER_BITS bit vector. Supports query, insert and clear through a valid/ready request port and a one-cycle response pulse. The game FSM uses it for guess validation, and it can be loaded at runtime instead of only from a synthesis-time constant.

---
 rtl/bloom_pkg.sv | 23 ++
 rtl/bloom_hash.sv | 32 +++
 rtl/bloom_filter_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/bloom_pkg.sv
// Shared encodings, FSM states and the default hash coefficients for the
// Wordle dictionary Bloom filter.
package bloom_pkg;

    localparam logic [1:0] OP_QUERY  = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HASH  = 2'd1,
        CLEAR = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Coefficient (hash i, letter j) sits at [(i*5+j)*8 +: 8]; hash 0 letter 0 is the LSB byte.
    localparam logic [79:0] DEF_HASH_PARAMS = {
        8'h77, 8'hdc, 8'h77, 8'hfa, 8'hb6,
        8'hf4, 8'hf9, 8'h85, 8'hc5, 8'he6
    };

endpackage

// File: rtl/bloom_hash.sv
// Combinational linear hash: index = sum_j coef[k][j] * letter_j, modulo FILTER_BITS.
module bloom_hash #(
    parameter int LETTERS     = 5,
    parameter int LETTER_W    = 5,
    parameter int NUM_HASH    = 2,
    parameter int FILTER_BITS = 256,
    parameter logic [NUM_HASH*LETTERS*$clog2(FILTER_BITS)-1:0] HASH_PARAMS = '0
) (
    input  logic [LETTERS*LETTER_W-1:0]                      i_word,
    input  logic [((NUM_HASH > 1) ? $clog2(NUM_HASH) : 1)-1:0] i_k,
    output logic [$clog2(FILTER_BITS)-1:0]                   o_idx
);

    localparam int IDX_W = $clog2(FILTER_BITS);

    logic [NUM_HASH-1:0][IDX_W-1:0] w_idx_all;

    for (genvar gi = 0; gi < NUM_HASH; gi++) begin : g_hash
        logic [IDX_W-1:0] w_sum;
        always_comb begin
            w_sum = '0;
            for (int j = 0; j < LETTERS; j++) begin
                w_sum = w_sum + HASH_PARAMS[(gi*LETTERS+j)*IDX_W +: IDX_W]
                              * IDX_W'(i_word[LETTER_W*j +: LETTER_W]);
            end
        end
        assign w_idx_all[gi] = w_sum;
    end

    assign o_idx = w_idx_all[i_k];

endmodule

// File: rtl/bloom_filter_seq.sv
// Writable Bloom-filter membership store: one hash per clock against a
// register filter, with query/insert/clear via a valid/ready request port.
module bloom_filter_seq
    import bloom_pkg::*;
#(
    parameter int LETTERS     = 5,
    parameter int LETTER_W    = 5,
    parameter int NUM_HASH    = 2,
    parameter int FILTER_BITS = 256,
    parameter logic [NUM_HASH*LETTERS*$clog2(FILTER_BITS)-1:0] HASH_PARAMS = DEF_HASH_PARAMS,
    parameter logic [FILTER_BITS-1:0] INIT_FILTER = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_op,
    input  logic [LETTERS*LETTER_W-1:0]   req_word,
    output logic                          resp_valid,
    output logic                          resp_hit,
    output logic [15:0]                   insert_count
);

    localparam int IDX_W = $clog2(FILTER_BITS);
    localparam int K_W   = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_HASH - 1);

    state_t                        r_state;
    state_t                        w_next;
    logic [LETTERS*LETTER_W-1:0]   r_word;
    logic [1:0]                    r_op;
    logic [K_W-1:0]                r_k;
    logic                          r_acc;
    logic [FILTER_BITS-1:0]        r_filter;
    logic                          r_resp_valid;
    logic                          r_resp_hit;
    logic [15:0]                   r_count;
    logic [IDX_W-1:0]              w_idx;

    bloom_hash #(
        .LETTERS     (LETTERS),
        .LETTER_W    (LETTER_W),
        .NUM_HASH    (NUM_HASH),
        .FILTER_BITS (FILTER_BITS),
        .HASH_PARAMS (HASH_PARAMS)
    ) u_hash (
        .i_word (r_word),
        .i_k    (r_k),
        .o_idx  (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = (req_op == OP_CLEAR) ? CLEAR : HASH;
            HASH:    if (r_k == K_LAST) w_next = RESP;
            CLEAR:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Filter reads in HASH see writes from earlier hash cycles of the same insert.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filter     <= INIT_FILTER;
            r_word       <= '0;
            r_op         <= OP_QUERY;
            r_k          <= '0;
            r_acc        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_count      <= '0;
        end else begin
            r_resp_valid <= (r_state == RESP);
            r_resp_hit   <= (r_state == RESP) & r_acc;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_word <= req_word;
                        r_op   <= req_op;
                        r_k    <= '0;
                        r_acc  <= 1'b1;
                    end
                end
                HASH: begin
                    r_acc <= r_acc & r_filter[w_idx];
                    if (r_op == OP_INSERT) r_filter[w_idx] <= 1'b1;
                    r_k <= r_k + 1'b1;
                end
                CLEAR: begin
                    r_filter <= '0;
                    r_acc    <= 1'b0;
                    r_count  <= '0;
                end
                RESP: begin
                    if (r_op == OP_INSERT && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign resp_valid   = r_resp_valid;
    assign resp_hit     = r_resp_hit;
    assign insert_count = r_count;

endmodule
